// File: rtl/pc_control_unit.sv
// ============================================================================
// Module      : pc_control_unit
// Description : Fetch-stage program counter with run/step/halt debug control,
//               jump > branch > sequential next-PC selection, stall hold and
//               saturating cycle / instruction counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_control_unit #(
  parameter int unsigned       NBITS       = 32,
  parameter logic [NBITS-1:0]  RESET_ADDR  = '0,
  parameter int unsigned       INSTR_BYTES = 4,
  parameter int unsigned       CNT_BITS    = 32
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic                i_run_mode,
  input  logic                i_step,
  input  logic                i_clear,
  input  logic                i_stall,
  input  logic                i_jump,
  input  logic [NBITS-1:0]    i_jump_target,
  input  logic                i_branch_taken,
  input  logic [NBITS-1:0]    i_branch_target,
  input  logic                i_halt,
  output logic [NBITS-1:0]    o_pc,
  output logic [NBITS-1:0]    o_pc_next_seq,
  output logic                o_fetch_valid,
  output logic                o_halted,
  output logic [CNT_BITS-1:0] o_cycle_count,
  output logic [CNT_BITS-1:0] o_instr_count
);

  localparam logic [NBITS-1:0]    C_INC      = NBITS'(INSTR_BYTES);
  localparam logic [NBITS-1:0]    C_LOW_MASK = NBITS'(INSTR_BYTES - 1);
  localparam logic [CNT_BITS-1:0] C_CNT_ONE  = {{(CNT_BITS-1){1'b0}}, 1'b1};
  localparam logic [CNT_BITS-1:0] C_CNT_MAX  = {CNT_BITS{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_STEP   = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [NBITS-1:0]    pc_q, pc_d;
  logic [CNT_BITS-1:0] cyc_q, cyc_d;
  logic [CNT_BITS-1:0] ins_q, ins_d;

  logic                active;
  logic                adv;
  logic [NBITS-1:0]    pc_seq;
  logic [CNT_BITS-1:0] cyc_inc;
  logic [CNT_BITS-1:0] ins_inc;

  // An active cycle is one the debug unit lets the pipeline fetch in;
  // it only advances the PC when the hazard unit is not stalling.
  assign active  = (state_q == ST_RUN) | ((state_q == ST_STEP) & i_step);
  assign adv     = active & ~i_stall;
  assign pc_seq  = pc_q + C_INC;
  assign cyc_inc = (cyc_q == C_CNT_MAX) ? cyc_q : cyc_q + C_CNT_ONE;
  assign ins_inc = (ins_q == C_CNT_MAX) ? ins_q : ins_q + C_CNT_ONE;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cyc_d   = cyc_q;
    ins_d   = ins_q;

    if (i_clear) begin
      state_d = ST_IDLE;
      pc_d    = RESET_ADDR;
      cyc_d   = '0;
      ins_d   = '0;
    end else begin
      if ((state_q == ST_IDLE) && i_start) begin
        state_d = i_run_mode ? ST_RUN : ST_STEP;
      end

      if (active) begin
        cyc_d = cyc_inc;
      end

      // A redirect squashes a HALT decoded on the wrong path.
      if (adv) begin
        if (i_jump) begin
          pc_d  = i_jump_target & ~C_LOW_MASK;
          ins_d = ins_inc;
        end else if (i_branch_taken) begin
          pc_d  = i_branch_target & ~C_LOW_MASK;
          ins_d = ins_inc;
        end else if (i_halt) begin
          state_d = ST_HALTED;
        end else begin
          pc_d  = pc_seq;
          ins_d = ins_inc;
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_ADDR;
      cyc_q   <= '0;
      ins_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cyc_q   <= cyc_d;
      ins_q   <= ins_d;
    end
  end

  assign o_pc          = pc_q;
  assign o_pc_next_seq = pc_seq;
  assign o_fetch_valid = active;
  assign o_halted      = (state_q == ST_HALTED);
  assign o_cycle_count = cyc_q;
  assign o_instr_count = ins_q;

endmodule

`default_nettype wire

// File: tb/tb_pc_control_unit.sv
// ============================================================================
// Module      : tb_pc_control_unit
// Description : Self-checking bench for pc_control_unit (32-bit and 4-bit
//               counter instances driven in lockstep).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_control_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0, run_mode = 1'b0, step = 1'b0, clear = 1'b0;
  logic        stall = 1'b0, jump = 1'b0, br = 1'b0, halt = 1'b0;
  logic [31:0] jtgt = '0, btgt = '0;

  logic [31:0] pc, seq, cyc, ins;
  logic        fv, halted;
  logic [31:0] pc4, seq4;
  logic [3:0]  cyc4, ins4;
  logic        fv4, halted4;

  int n_checks = 0;
  int n_fail   = 0;

  pc_control_unit dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_run_mode(run_mode),
    .i_step(step), .i_clear(clear), .i_stall(stall), .i_jump(jump),
    .i_jump_target(jtgt), .i_branch_taken(br), .i_branch_target(btgt),
    .i_halt(halt), .o_pc(pc), .o_pc_next_seq(seq), .o_fetch_valid(fv),
    .o_halted(halted), .o_cycle_count(cyc), .o_instr_count(ins)
  );

  pc_control_unit #(.CNT_BITS(4)) dut4 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_run_mode(run_mode),
    .i_step(step), .i_clear(clear), .i_stall(stall), .i_jump(jump),
    .i_jump_target(jtgt), .i_branch_taken(br), .i_branch_target(btgt),
    .i_halt(halt), .o_pc(pc4), .o_pc_next_seq(seq4), .o_fetch_valid(fv4),
    .o_halted(halted4), .o_cycle_count(cyc4), .o_instr_count(ins4)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running required finished");
    $fatal(1, "watchdog");
  end

  // Reference model: debug mode as a plain label, counters as unbounded totals
  localparam int M_IDLE = 0, M_RUN = 1, M_STEP = 2, M_HALT = 3;
  int          m_mode;
  logic [31:0] m_pc;
  longint      m_cyc, m_ins;
  logic        e_fv, s_fv;
  logic [31:0] e_seq, s_seq;

  function automatic logic [31:0] sat32(longint v);
    return (v > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : v[31:0];
  endfunction

  function automatic logic [3:0] sat4(longint v);
    return (v > 15) ? 4'hF : v[3:0];
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_pc = 32'h0; m_cyc = 0; m_ins = 0;
  endtask

  task automatic model_step();
    bit fetching;
    if (clear) begin
      model_reset();
      return;
    end
    fetching = (m_mode == M_RUN) || (m_mode == M_STEP && step);
    if (m_mode == M_IDLE && start) m_mode = run_mode ? M_RUN : M_STEP;
    if (fetching) m_cyc++;
    if (fetching && !stall) begin
      if (jump)      begin m_pc = jtgt & 32'hFFFF_FFFC; m_ins++; end
      else if (br)   begin m_pc = btgt & 32'hFFFF_FFFC; m_ins++; end
      else if (halt) m_mode = M_HALT;
      else           begin m_pc = m_pc + 32'd4; m_ins++; end
    end
  endtask

  // Samples combinational outputs late in the cycle, advances model and clock
  task automatic tick();
    #2;
    s_fv  = fv;
    s_seq = seq;
    e_fv  = (m_mode == M_RUN) || (m_mode == M_STEP && step);
    e_seq = m_pc + 32'd4;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 0; run_mode = 0; step = 0; clear = 0; stall = 0;
    jump = 0; br = 0; halt = 0; jtgt = '0; btgt = '0;
  endtask

  task automatic do_clear();
    idle_inputs();
    clear = 1; tick(); clear = 0;
  endtask

  task automatic start_run();
    start = 1; run_mode = 1; tick(); start = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    #1 rst = 1;
    #2;
    n_checks++;
    if (pc !== 32'h0 || halted !== 1'b0 || fv !== 1'b0 || cyc !== 32'h0 || ins !== 32'h0 || cyc4 !== 4'h0) begin
      n_fail++;
      $display("FAIL reset: pc=%h halted=%b fv=%b cyc=%0d ins=%0d cyc4=%0d required 0/0/0/0/0/0", pc, halted, fv, cyc, ins, cyc4);
    end
    @(posedge clk); #1;
    rst = 0;
    model_reset();
  endtask

  task automatic test_run_sequence();
    start_run();
    n_checks++;
    if (pc !== 32'h0) begin n_fail++; $display("FAIL run_start_pc: got %h required 0", pc); end
    for (int i = 1; i <= 5; i++) begin
      tick();
      n_checks++;
      if (pc !== 32'(4 * i) || s_fv !== 1'b1) begin
        n_fail++; $display("FAIL run_pc[%0d]: pc=%h fv=%b required pc=%h fv=1", i, pc, s_fv, 32'(4 * i));
      end
    end
    n_checks++;
    if (ins !== 32'd5 || cyc !== 32'd5) begin
      n_fail++; $display("FAIL run_counts: ins=%0d cyc=%0d required 5/5", ins, cyc);
    end
  endtask

  task automatic test_priority();
    do_clear();
    start_run();
    repeat (4) tick();
    n_checks++;
    if (pc !== 32'h10) begin n_fail++; $display("FAIL prio_setup: got %h required 10", pc); end
    jump = 1; jtgt = 32'h40; br = 1; btgt = 32'h80;
    tick();
    n_checks++;
    if (pc !== 32'h40) begin n_fail++; $display("FAIL jump_over_branch: got %h required 40", pc); end
    jump = 0; btgt = 32'h83;
    tick();
    br = 0;
    n_checks++;
    if (pc !== 32'h80) begin n_fail++; $display("FAIL branch_mask: got %h required 80", pc); end
  endtask

  task automatic test_stall();
    logic [31:0] cyc0;
    do_clear();
    start_run();
    jump = 1; jtgt = 32'h20; tick(); jump = 0;
    cyc0 = cyc;
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      br = (i == 1); btgt = 32'h100;
      tick();
      n_checks++;
      if (pc !== 32'h20 || s_fv !== 1'b1) begin
        n_fail++; $display("FAIL stall_hold[%0d]: pc=%h fv=%b required pc=20 fv=1", i, pc, s_fv);
      end
    end
    br = 0;
    n_checks++;
    if (cyc !== cyc0 + 32'd3) begin n_fail++; $display("FAIL stall_cycles: got %0d required %0d", cyc, cyc0 + 32'd3); end
    stall = 0;
    tick();
    n_checks++;
    if (pc !== 32'h24) begin n_fail++; $display("FAIL stall_release: got %h required 24", pc); end
  endtask

  task automatic test_step();
    logic [31:0] exp_pc;
    do_clear();
    start = 1; run_mode = 0; tick(); start = 0; run_mode = 1;
    exp_pc = 32'h0;
    for (int k = 0; k < 12; k++) begin
      step  = (k % 4 == 0);
      stall = (k == 4);
      tick();
      if (k == 0 || k == 8) exp_pc = exp_pc + 32'd4;
      n_checks++;
      if (pc !== exp_pc || s_fv !== (k % 4 == 0)) begin
        n_fail++; $display("FAIL step[%0d]: pc=%h fv=%b required pc=%h fv=%b", k, pc, s_fv, exp_pc, (k % 4 == 0));
      end
    end
    step = 0; stall = 0;
    n_checks++;
    if (cyc !== 32'd3 || ins !== 32'd2) begin
      n_fail++; $display("FAIL step_counts: cyc=%0d ins=%0d required 3/2", cyc, ins);
    end
  endtask

  task automatic test_halt();
    logic [31:0] cyc0, ins0;
    do_clear();
    start_run();
    jump = 1; jtgt = 32'h30; tick(); jump = 0;
    halt = 1; tick(); halt = 0;
    n_checks++;
    if (halted !== 1'b1 || pc !== 32'h30) begin
      n_fail++; $display("FAIL halt_enter: halted=%b pc=%h required 1/30", halted, pc);
    end
    cyc0 = cyc; ins0 = ins;
    start = 1; run_mode = 1;
    repeat (3) tick();
    start = 0;
    n_checks++;
    if (halted !== 1'b1 || pc !== 32'h30 || cyc !== cyc0 || ins !== ins0 || s_fv !== 1'b0) begin
      n_fail++; $display("FAIL halt_freeze: halted=%b pc=%h cyc=%0d ins=%0d fv=%b required 1/30/%0d/%0d/0", halted, pc, cyc, ins, s_fv, cyc0, ins0);
    end
    do_clear();
    n_checks++;
    if (halted !== 1'b0 || pc !== 32'h0 || cyc !== 32'h0 || ins !== 32'h0) begin
      n_fail++; $display("FAIL halt_clear: halted=%b pc=%h cyc=%0d ins=%0d required 0/0/0/0", halted, pc, cyc, ins);
    end
    start_run();
    halt = 1; jump = 1; jtgt = 32'h50; tick(); halt = 0; jump = 0;
    n_checks++;
    if (pc !== 32'h50 || halted !== 1'b0) begin
      n_fail++; $display("FAIL halt_squashed: pc=%h halted=%b required 50/0", pc, halted);
    end
  endtask

  task automatic test_saturation_wrap();
    do_clear();
    start_run();
    repeat (20) tick();
    n_checks++;
    if (cyc4 !== 4'hF || ins4 !== 4'hF || cyc !== 32'd20 || ins !== 32'd20) begin
      n_fail++; $display("FAIL saturate: cyc4=%0d ins4=%0d cyc=%0d ins=%0d required 15/15/20/20", cyc4, ins4, cyc, ins);
    end
    jump = 1; jtgt = 32'hFFFF_FFFF; tick(); jump = 0;
    n_checks++;
    if (pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_setup: got %h required fffffffc", pc); end
    tick();
    n_checks++;
    if (pc !== 32'h0 || s_seq !== 32'h0) begin
      n_fail++; $display("FAIL wrap: pc=%h seq=%h required 0/0", pc, s_seq);
    end
  endtask

  task automatic test_async_reset();
    do_clear();
    start_run();
    repeat (3) tick();
    #3 rst = 1;
    #1;
    n_checks++;
    if (pc !== 32'h0 || pc4 !== 32'h0 || cyc !== 32'h0 || fv !== 1'b0) begin
      n_fail++; $display("FAIL async_reset: pc=%h pc4=%h cyc=%0d fv=%b required 0/0/0/0", pc, pc4, cyc, fv);
    end
    @(posedge clk); #1;
    rst = 0;
    model_reset();
    tick();
    n_checks++;
    if (pc !== 32'h0 || s_fv !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_idle: pc=%h fv=%b required 0/0", pc, s_fv);
    end
  endtask

  task automatic test_random();
    do_clear();
    for (int i = 0; i < 600; i++) begin
      clear    = ($urandom % 40) == 0;
      start    = ($urandom % 6) == 0;
      run_mode = $urandom % 2;
      step     = ($urandom % 3) == 0;
      stall    = ($urandom % 4) == 0;
      jump     = ($urandom % 8) == 0;
      br       = ($urandom % 6) == 0;
      halt     = ($urandom % 12) == 0;
      jtgt     = $urandom;
      btgt     = $urandom;
      tick();
      n_checks++;
      if (pc !== m_pc || pc4 !== m_pc || halted !== (m_mode == M_HALT) || s_fv !== e_fv || s_seq !== e_seq ||
          cyc !== sat32(m_cyc) || ins !== sat32(m_ins) || cyc4 !== sat4(m_cyc) || ins4 !== sat4(m_ins)) begin
        n_fail++;
        $display("FAIL random[%0d]: pc=%h halted=%b fv=%b seq=%h cyc=%0d ins=%0d cyc4=%0d ins4=%0d required pc=%h halted=%b fv=%b seq=%h cyc=%0d ins=%0d cyc4=%0d ins4=%0d",
                 i, pc, halted, s_fv, s_seq, cyc, ins, cyc4, ins4,
                 m_pc, (m_mode == M_HALT), e_fv, e_seq, sat32(m_cyc), sat32(m_ins), sat4(m_cyc), sat4(m_ins));
      end
    end
    idle_inputs();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_run_sequence();
    test_priority();
    test_stall();
    test_step();
    test_halt();
    test_saturation_wrap();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pc_control_unit.md
Name: pc_control_unit

Overview:
- Parametrised program-counter block for the pipelined MIPS fetch stage; replaces the bare PC register.
- Adds run/step/halt control for the debug unit, a fixed next-PC priority (jump > branch > sequential), stall hold, HALT detection and saturating cycle/instruction counters.
- Drives the instruction-memory address and the IF/ID PC+4 field.

Parameters:
- NBITS, 32, PC and target width.
- RESET_ADDR, 0, PC value after reset or clear.
- INSTR_BYTES, 4, sequential increment; must be a power of 2; target low log2(INSTR_BYTES) bits are forced to 0.
- CNT_BITS, 32, width of both counters.

Ports:
- i_clk, input, 1, clock; rising-edge active.
- i_rst, input, 1, asynchronous active-high reset.
- i_start, input, 1, debug start pulse; sampled only in IDLE.
- i_run_mode, input, 1, 1 = continuous, 0 = step; sampled with i_start.
- i_step, input, 1, one-cycle step pulse; used in STEP only.
- i_clear, input, 1, synchronous return to IDLE from any state.
- i_stall, input, 1, hazard-unit stall; blocks all PC updates.
- i_jump, input, 1, jump redirect valid.
- i_jump_target, input, NBITS, jump address.
- i_branch_taken, input, 1, taken-branch redirect valid.
- i_branch_target, input, NBITS, branch address.
- i_halt, input, 1, HALT opcode decoded at the current o_pc.
- o_pc, output, NBITS, current fetch address.
- o_pc_next_seq, output, NBITS, o_pc + INSTR_BYTES (combinational, wraps mod 2^NBITS).
- o_fetch_valid, output, 1, fetch in this cycle is real.
- o_halted, output, 1, high in HALTED.
- o_cycle_count, output, CNT_BITS, active cycles.
- o_instr_count, output, CNT_BITS, PC advances.

Behaviour:
- Reset (async, i_rst = 1): state = IDLE; o_pc = RESET_ADDR; both counters = 0; o_halted = 0; o_fetch_valid = 0. Reset takes effect mid-operation immediately, whatever the state.
- States and transitions:
  - IDLE: PC holds. i_start & i_run_mode goes to RUN; i_start & !i_run_mode goes to STEP.
  - RUN: adv = ~i_stall each cycle.
  - STEP: adv = i_step & ~i_stall. i_step while stalled is dropped, not queued.
  - HALTED: PC holds; o_halted = 1. Leaves only on i_clear or reset.
- i_clear has priority over all other inputs except reset. Next edge: state = IDLE, o_pc = RESET_ADDR, counters = 0.
- o_fetch_valid = (state == RUN) | (state == STEP & i_step). It is combinational and stays high during a stall; IF/ID holds the instruction.
- Next PC when adv:
  - i_jump: masked i_jump_target.
  - else i_branch_taken: masked i_branch_target.
  - else i_halt: PC holds and state goes to HALTED.
  - else o_pc + INSTR_BYTES.
- A redirect in the same cycle as i_halt wins, because the HALT is on the squashed path; the state is unchanged.
- When not adv, the PC holds. A redirect asserted during a stall is ignored; upstream holds it until the stall drops.
- Latency: one edge from adv to the new o_pc.
- Sequential increment wraps: 0xFFFFFFFC + 4 gives 0x00000000.
- o_instr_count increments on every adv cycle that changes PC or takes a redirect. It does not increment on the halting cycle.
- o_cycle_count increments every cycle in RUN, and in STEP only on cycles with i_step, stalled or not. It does not count in IDLE or HALTED.
- Both counters saturate at 2^CNT_BITS - 1.
- i_start outside IDLE is ignored. i_run_mode changes after start are ignored.

Test Plan:
- Reset, then i_start = 1, i_run_mode = 1, no stalls for 5 cycles -> o_pc steps 0, 4, 8, 12, 16, 20; o_instr_count = 5; o_cycle_count = 5.
- RUN at o_pc = 0x10 with i_jump = 1 (target 0x40) and i_branch_taken = 1 (target 0x80) in the same cycle -> o_pc = 0x40. Separately, branch target 0x83 -> o_pc = 0x80.
- i_stall high for 3 cycles at o_pc = 0x20, with i_branch_taken pulsed during the stall -> o_pc stays 0x20 and does not take the branch; after the stall, o_pc = 0x24; o_cycle_count still advances during the stall.
- STEP mode with three i_step pulses spaced 4 cycles apart, one of them during i_stall -> o_pc goes 0 to 4 to 8 only; o_fetch_valid is high only on the pulse cycles.
- i_halt at o_pc = 0x30 -> next edge o_halted = 1, o_pc = 0x30, counters freeze; then i_clear -> IDLE, o_pc = 0, counters 0. Separately, i_halt with i_jump (target 0x50) -> o_pc = 0x50, not halted.
- CNT_BITS = 4, RUN for 20 cycles -> counters saturate at 15. Also assert i_rst asynchronously between clock edges mid-run -> o_pc = 0 immediately.
